// File: rtl/spi_slave_pkg.sv
// Shared SPI slave definitions: bus mode, default geometry and frame state encoding.
package spi_slave_pkg;

    localparam logic        SPI_CPOL            = 1'b0;
    localparam logic        SPI_CPHA            = 1'b0;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

endpackage

// File: rtl/spi_slave_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled in the clk_i domain; echoes each
// received word back as the next transmitted word.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  ss_i,
    input  logic                  sdi_i,
    output logic                  sdo_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    logic sclk_s, ss_s, sdi_s;
    logic sclk_lvl_c;
    logic sclk_prev_q, ss_prev_q;
    logic sclk_rise_c, sclk_fall_c, ss_fall_c, ss_rise_c;

    frame_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] echo_q, echo_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  reload_q, reload_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  sdo_q, sdo_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sclk_i),
        .q_o   (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ss_i),
        .q_o   (ss_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sdi_i),
        .q_o   (sdi_s)
    );

    // Normalise SCLK so that "rise" is always the sampling edge.
    assign sclk_lvl_c  = sclk_s ^ SPI_CPOL;
    assign sclk_rise_c =  sclk_lvl_c & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_lvl_c &  sclk_prev_q;
    assign ss_fall_c   = ~ss_s &  ss_prev_q;
    assign ss_rise_c   =  ss_s & ~ss_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            state_q     <= ST_IDLE;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            echo_q      <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_lvl_c;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            echo_q      <= echo_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            rx_valid_q  <= rx_valid_d;
            sdo_q       <= sdo_d;
        end
    end

    // Frame control: ss edges win over a coincident SCLK edge. A frame only
    // starts on a seen ss falling edge, so a reset mid-frame stays idle.
    always_comb begin
        state_d    = state_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        echo_d     = echo_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        reload_d   = reload_q;
        rx_valid_d = 1'b0;

        if (ss_fall_c) begin
            state_d   = ST_ACTIVE;
            bit_cnt_d = '0;
            rx_sr_d   = '0;
            tx_sr_d   = echo_q;
            reload_d  = 1'b0;
        end else if (ss_rise_c) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            rx_sr_d   = '0;
            reload_d  = 1'b0;
        end else if (state_q == ST_ACTIVE) begin
            if (sclk_rise_c) begin
                rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], sdi_s};
                if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    rx_data_d  = rx_sr_d;
                    echo_d     = rx_sr_d;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end else if (sclk_fall_c) begin
                if (reload_q) begin
                    tx_sr_d  = echo_q;
                    reload_d = 1'b0;
                end else begin
                    tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end

        sdo_d = (state_d == ST_ACTIVE) ? tx_sr_d[DATA_WIDTH-1] : 1'b0;
    end

    assign sdo_o      = sdo_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frame vectors from a table plus hand-written
// sequences for idle SCLK, aborted words, free-running SCLK and mid-frame reset.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q [$];
    logic       valid_prev = 1'b0;

    typedef struct {
        logic        rst_first;
        int          n;
        int          half;
        logic [31:0] tx;       // word w occupies bits [8w+7:8w]
        logic [31:0] exp_sdo;
    } frame_vec_t;

    frame_vec_t vecs [4];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sclk_i     (sclk),
        .ss_i       (ss),
        .sdi_i      (sdi),
        .sdo_o      (sdo_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o)
    );

    always #5 clk = ~clk;

    // Collect received words and flag pulses longer than one cycle.
    always @(negedge clk) begin
        if (rx_valid_o) begin
            rx_q.push_back(rx_data_o);
            checks++;
            if (valid_prev) begin
                errors++;
                $display("FAIL rx_valid_width: got pulse of 2+ cycles, expected 1 cycle");
            end
        end
        valid_prev <= rx_valid_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] w, input int nbits, input int half,
                             output logic [7:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = w[7-i];
            #(half);
            miso[7-i] = sdo_o;
            sclk = 1'b1;
            #(half);
            sclk = 1'b0;
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = 8'hxx;
        if (rx_q.size() > 0) act = rx_q.pop_front();
        check(name, 32'(act), 32'(exp));
    endtask

    initial begin
        logic [7:0] miso;
        logic       sdo_bad;

        vecs[0] = '{rst_first: 1'b1, n: 2, half: 500, tx: 32'h0000_3CA5, exp_sdo: 32'h0000_A500};
        vecs[1] = '{rst_first: 1'b1, n: 3, half: 40,  tx: 32'h00FF_8001, exp_sdo: 32'h0080_0100};
        vecs[2] = '{rst_first: 1'b0, n: 2, half: 50,  tx: 32'h0000_C35A, exp_sdo: 32'h0000_5AFF};
        vecs[3] = '{rst_first: 1'b0, n: 1, half: 40,  tx: 32'h0000_007E, exp_sdo: 32'h0000_00C3};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sdo", 32'(sdo_o), 32'h0);
        check("rst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("rst_rx_data", 32'(rx_data_o), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames; frames without reset continue the echo chain
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].rst_first) do_reset();
            rx_q.delete();
            ss = 1'b0;
            #(vecs[v].half);
            for (int w = 0; w < vecs[v].n; w++) begin
                send_bits(vecs[v].tx[8*w +: 8], 8, vecs[v].half, miso);
                check($sformatf("vec%0d_sdo%0d", v, w), 32'(miso), 32'(vecs[v].exp_sdo[8*w +: 8]));
            end
            ss = 1'b1;
            #1000;
            check($sformatf("vec%0d_rx_count", v), 32'(rx_q.size()), 32'(vecs[v].n));
            for (int w = 0; w < vecs[v].n; w++)
                check_rx($sformatf("vec%0d_rx%0d", v, w), vecs[v].tx[8*w +: 8]);
            check($sformatf("vec%0d_rx_data_hold", v), 32'(rx_data_o),
                  32'(vecs[v].tx[8*(vecs[v].n-1) +: 8]));
        end

        // ss high with SCLK toggling for 20 us: nothing received, sdo stays 0
        rx_q.delete();
        sdo_bad = 1'b0;
        ss = 1'b1;
        for (int k = 0; k < 40; k++) begin
            sdi = 1'($urandom);
            sclk = ~sclk;
            #500;
            if (sdo_o !== 1'b0) sdo_bad = 1'b1;
        end
        sclk = 1'b0;
        #1000;
        check("idle_sdo_nonzero", 32'(sdo_bad), 32'h0);
        check("idle_rx_count", 32'(rx_q.size()), 32'h0);

        // Aborted 5-bit word then a full 0x81
        do_reset();
        rx_q.delete();
        ss = 1'b0;
        #500;
        send_bits(8'hFF, 5, 500, miso);
        ss = 1'b1;
        #1000;
        check("abort_rx_count", 32'(rx_q.size()), 32'h0);
        check("abort_rx_data", 32'(rx_data_o), 32'h0);
        ss = 1'b0;
        #500;
        send_bits(8'h81, 8, 500, miso);
        ss = 1'b1;
        #1000;
        check("abort_next_sdo", 32'(miso), 32'h0);
        check("abort_next_count", 32'(rx_q.size()), 32'h1);
        check_rx("abort_next_rx", 8'h81);

        // Free-running 1 MHz SCLK, ss low from 1 us to 201 us, sdi = 0
        do_reset();
        rx_q.delete();
        sdi = 1'b0;
        for (int k = 0; k <= 404; k++) begin
            if (k == 2)   ss = 1'b0;
            if (k == 402) ss = 1'b1;
            sclk = k[0];
            #500;
        end
        sclk = 1'b0;
        #1000;
        check("free_rx_count", 32'(rx_q.size()), 32'd25);
        for (int w = 0; w < 25; w++)
            check_rx($sformatf("free_rx%0d", w), 8'h00);

        // Reset after 4 bits of 0x5A; stays idle until a fresh ss falling edge
        do_reset();
        rx_q.delete();
        ss = 1'b0;
        #500;
        send_bits(8'h5A, 4, 500, miso);
        do_reset();
        check("midrst_sdo", 32'(sdo_o), 32'h0);
        check("midrst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("midrst_rx_data", 32'(rx_data_o), 32'h0);
        send_bits(8'hFF, 8, 500, miso);
        #1000;
        check("midrst_no_frame_rx", 32'(rx_q.size()), 32'h0);
        check("midrst_no_frame_sdo", 32'(miso), 32'h0);
        ss = 1'b1;
        #500;
        ss = 1'b0;
        #500;
        send_bits(8'h12, 8, 500, miso);
        ss = 1'b1;
        #1000;
        check("midrst_next_sdo", 32'(miso), 32'h0);
        check("midrst_next_count", 32'(rx_q.size()), 32'h1);
        check_rx("midrst_next_rx", 8'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
